// File: rtl/pipelined_chain_adder.sv
// ---------------------------------------------------------------------------------------------
// pipelined_chain_adder
//
// NUM_CH independent channels. Each channel has two carry-chained DATA_WIDTH-bit adders:
//   lo   = a + b + cin
//   hi   = c + d + carry(lo)
//   cout = carry(hi)
// There is no carry between channels. The datapath has two pipeline stages with
// valid/ready flow control:
//   S1 registers lo, carry(lo), c and d.
//   S2 is the output register. It holds {hi, lo} and cout.
// A saturating counter counts delivered beats that have any cout bit set.
//
// Ports
//   clk_i          clock; all state changes on the rising edge
//   rst_i          synchronous, active-high reset
//   in_valid_i     input beat present
//   in_ready_o     block accepts the input beat this cycle
//   a_i, b_i       lo-adder operands; channel n = [n*DATA_WIDTH +: DATA_WIDTH]
//   c_i, d_i       hi-adder operands; same channel packing
//   cin_i          carry-in, bit n for channel n
//   out_valid_o    result beat present
//   out_ready_i    sink accepts the result this cycle
//   sum_o          [n*DW +: DW] = lo of channel n; [(NUM_CH+n)*DW +: DW] = hi of channel n
//   cout_o         carry-out of the hi adder, bit n for channel n
//   cout_events_o  saturating count of delivered beats with |cout
// ---------------------------------------------------------------------------------------------
module pipelined_chain_adder #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   a_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   b_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   c_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   d_i,
    input  logic [NUM_CH-1:0]              cin_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [2*NUM_CH*DATA_WIDTH-1:0] sum_o,
    output logic [NUM_CH-1:0]              cout_o,
    output logic [CNT_WIDTH-1:0]           cout_events_o
);

    localparam int unsigned VecW = NUM_CH * DATA_WIDTH;

    // One DATA_WIDTH+1 bit add. The MSB of the result is the carry-out.
    function automatic logic [DATA_WIDTH:0] add3(input logic [DATA_WIDTH-1:0] x,
                                                 input logic [DATA_WIDTH-1:0] y,
                                                 input logic                  ci);
        return {1'b0, x} + {1'b0, y} + {{DATA_WIDTH{1'b0}}, ci};
    endfunction

    // ------------------------------------------------------------------ state
    logic                s1_valid_q, s1_valid_d;
    logic [VecW-1:0]     s1_lo_q, s1_lo_d;
    logic [NUM_CH-1:0]   s1_c1_q, s1_c1_d;
    logic [VecW-1:0]     s1_c_q, s1_c_d;
    logic [VecW-1:0]     s1_d_q, s1_d_d;

    logic                out_valid_q, out_valid_d;
    logic [2*VecW-1:0]   sum_q, sum_d;
    logic [NUM_CH-1:0]   cout_q, cout_d;
    logic [CNT_WIDTH-1:0] events_q, events_d;

    // ------------------------------------------------------------- handshake
    logic s2_free;
    logic s1_adv;
    logic in_fire;
    logic out_fire;

    // S2 can take a new beat if it is empty or is being drained this cycle.
    assign s2_free  = ~out_valid_q | out_ready_i;
    assign s1_adv   = s1_valid_q & s2_free;
    // S1 can take a beat if it is empty or is moving into S2 this cycle.
    // This signal depends only on state and out_ready_i. Data inputs never reach it.
    assign in_ready_o = ~s1_valid_q | s2_free;
    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_q & out_ready_i;

    // ---------------------------------------------------------- stage-1 adds
    logic [VecW-1:0]   lo_vec;
    logic [NUM_CH-1:0] lo_carry;

    always_comb begin
        lo_vec   = '0;
        lo_carry = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            {lo_carry[n], lo_vec[n*DATA_WIDTH +: DATA_WIDTH]} =
                add3(a_i[n*DATA_WIDTH +: DATA_WIDTH], b_i[n*DATA_WIDTH +: DATA_WIDTH], cin_i[n]);
        end
    end

    // ---------------------------------------------------------- stage-2 adds
    logic [VecW-1:0]   hi_vec;
    logic [NUM_CH-1:0] hi_carry;

    always_comb begin
        hi_vec   = '0;
        hi_carry = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            {hi_carry[n], hi_vec[n*DATA_WIDTH +: DATA_WIDTH]} =
                add3(s1_c_q[n*DATA_WIDTH +: DATA_WIDTH], s1_d_q[n*DATA_WIDTH +: DATA_WIDTH],
                     s1_c1_q[n]);
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_lo_d     = s1_lo_q;
        s1_c1_d     = s1_c1_q;
        s1_c_d      = s1_c_q;
        s1_d_d      = s1_d_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        events_d    = events_q;

        // Stage 1. A new beat replaces a beat that leaves S1 in the same cycle.
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_lo_d    = lo_vec;
            s1_c1_d    = lo_carry;
            s1_c_d     = c_i;
            s1_d_d     = d_i;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // Stage 2. Reload on advance. This also covers drain+reload in one cycle with no bubble.
        if (s1_adv) begin
            out_valid_d = 1'b1;
            sum_d       = {hi_vec, s1_lo_q};
            cout_d      = hi_carry;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        // Count only real deliveries, and stop at all-ones.
        if (out_fire && (|cout_q) && (events_q != {CNT_WIDTH{1'b1}})) begin
            events_d = events_q + CNT_WIDTH'(1);
        end
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= '0;
            s1_c1_q     <= '0;
            s1_c_q      <= '0;
            s1_d_q      <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= '0;
            events_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_c1_q     <= s1_c1_d;
            s1_c_q      <= s1_c_d;
            s1_d_q      <= s1_d_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            events_q    <= events_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign sum_o         = sum_q;
    assign cout_o        = cout_q;
    assign cout_events_o = events_q;

endmodule
